// File: rtl/lightcube_pkg.sv
// lightcube_pkg: shared cube geometry, frame type and source index constants
package lightcube_pkg;
  localparam int CUBE_N_DEF = 8;
  localparam int SRC_DEFAULT = 0;
  localparam int SRC_UART = 1;
  function automatic int frame_w(input int n);
    return n * n * n;
  endfunction
  localparam int FRAME_W = frame_w(CUBE_N_DEF);
  typedef logic [FRAME_W-1:0] frame_t;
endpackage

// File: rtl/frame_src_mux.sv
// frame_src_mux: NUM_SRC-to-1 frame/valid selector; out-of-range select yields no valid
module frame_src_mux #(
  parameter int FW = 512,
  parameter int NUM_SRC = 2,
  parameter int SEL_W = 1
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic [NUM_SRC*FW-1:0] frames_flat,
  input  logic [NUM_SRC-1:0]    valid,
  output logic [FW-1:0]         frame,
  output logic                  vld
);
  always_comb begin
    frame = '0;
    vld = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (SEL_W'(k) == sel) begin
        frame = frames_flat[k*FW +: FW];
        vld = valid[k];
      end
  end
endmodule

// File: rtl/frame_buffer_db.sv
// frame_buffer_db: double-buffered cube frame store with source select and drop/accept stats.
// Optional idle blanking enabled by FRAME_BUFFER_BLANK_TIMEOUT_EN.
module frame_buffer_db
  import lightcube_pkg::*;
#(
  parameter int CUBE_N = CUBE_N_DEF,
  parameter int NUM_SRC = 2,
  parameter int SEL_W = 1,
  parameter int CNT_W = 32,
  parameter int DROP_W = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  localparam int FW = frame_w(CUBE_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic [NUM_SRC*FW-1:0] src_frame_flat,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic                  scan_done,
  output logic [FW-1:0]         frame_cube_flat,
  output logic                  pending,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic                  stale
);
  logic [FW-1:0] mux_frame, front_q, front_d, back_q, back_d;
  logic mux_vld, pending_q, pending_d, sel_change, swap, drop, timeout;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  frame_src_mux #(.FW(FW), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_mux (
    .sel(src_sel),
    .frames_flat(src_frame_flat),
    .valid(src_valid),
    .frame(mux_frame),
    .vld(mux_vld)
  );
`ifdef FRAME_BUFFER_BLANK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES - 1);
  logic [IW-1:0] idle_q, idle_d;
  logic stale_q, stale_d;
  always_comb begin
    timeout = !mux_vld && !sel_change && idle_q == IDLE_MAX;
    idle_d = (mux_vld || sel_change) ? '0 : idle_q == IDLE_MAX ? idle_q : idle_q + 1'b1;
    stale_d = mux_vld ? 1'b0 : timeout ? 1'b1 : stale_q;
  end
  always_ff @(posedge clk) begin
    idle_q <= rst ? '0 : idle_d;
    stale_q <= rst ? 1'b0 : stale_d;
  end
  assign stale = stale_q;
`else
  assign timeout = 1'b0;
  assign stale = 1'b0;
`endif
  // A source switch discards the queued frame, so it also blocks the swap that cycle.
  always_comb begin
    sel_change = src_sel != sel_q;
    swap = scan_done && pending_q && !sel_change;
    drop = mux_vld && pending_q && !swap && !sel_change;
    front_d = timeout ? '0 : swap ? back_q : front_q;
    back_d = timeout ? '0 : mux_vld ? mux_frame : back_q;
    pending_d = !timeout && (mux_vld || (pending_q && !swap && !sel_change));
    frame_cnt_d = frame_cnt_q + CNT_W'(mux_vld);
    drop_cnt_d = (drop && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      front_q <= '0;
      back_q <= '0;
      pending_q <= 1'b0;
      sel_q <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      front_q <= front_d;
      back_q <= back_d;
      pending_q <= pending_d;
      sel_q <= src_sel;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign frame_cube_flat = front_q;
  assign pending = pending_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_frame_buffer_db.sv
// tb_frame_buffer_db: directed test-plan sequence plus random traffic against a queue-based model
module tb_frame_buffer_db;
  localparam int CUBE_N = 4, FW = 64, NUM_SRC = 3, SEL_W = 2, CNT_W = 8, DROP_W = 4, TMO = 100;
  logic clk = 1'b0, rst = 1'b0, scan_done = 1'b0;
  logic [SEL_W-1:0] src_sel = '0;
  logic [NUM_SRC*FW-1:0] src_frame_flat = '0;
  logic [NUM_SRC-1:0] src_valid = '0;
  logic [FW-1:0] frame_cube_flat;
  logic pending, stale;
  logic [CNT_W-1:0] frame_cnt;
  logic [DROP_W-1:0] drop_cnt;
  int vectors = 0, errs = 0;
  logic [FW-1:0] m_front = '0;
  logic [FW-1:0] m_q[$];
  int m_cnt = 0, m_drop = 0, m_idle = 0;
  logic [SEL_W-1:0] m_sel = '0;
  logic m_stale = 1'b0;
  frame_buffer_db #(.CUBE_N(CUBE_N), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W),
    .DROP_W(DROP_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .src_sel(src_sel), .src_frame_flat(src_frame_flat),
    .src_valid(src_valid), .scan_done(scan_done), .frame_cube_flat(frame_cube_flat),
    .pending(pending), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .stale(stale)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Model: at most one frame waits for display; a newer accept replaces (drops) it.
  task automatic step(input logic r, input logic [SEL_W-1:0] s, input logic [NUM_SRC-1:0] v, input logic sd);
    logic chg, acc;
    logic [FW-1:0] f;
    @(negedge clk);
    rst = r; src_sel = s; src_valid = v; scan_done = sd;
    for (int k = 0; k < NUM_SRC; k++) src_frame_flat[k*FW +: FW] = {$urandom, $urandom};
    chg = s != m_sel;
    acc = int'(s) < NUM_SRC && v[s];
    f = acc ? src_frame_flat[int'(s)*FW +: FW] : '0;
    if (r) begin
      m_front = '0; m_q.delete(); m_cnt = 0; m_drop = 0; m_sel = '0; m_idle = 0; m_stale = 1'b0;
    end else begin
      if (chg) m_q.delete();
      else if (sd && m_q.size() != 0) m_front = m_q.pop_front();
      if (acc) begin
        if (m_q.size() != 0) begin
          void'(m_q.pop_front());
          if (m_drop < 2**DROP_W - 1) m_drop++;
        end
        m_q.push_back(f);
        m_cnt = (m_cnt + 1) % (2**CNT_W);
      end
`ifdef FRAME_BUFFER_BLANK_TIMEOUT_EN
      if (acc || chg) m_idle = 0;
      else if (m_idle == TMO - 1) begin
        m_front = '0; m_q.delete(); m_stale = 1'b1;
      end else m_idle++;
      if (acc) m_stale = 1'b0;
`endif
      m_sel = s;
    end
    @(posedge clk);
    #1;
    chk("front", frame_cube_flat, m_front);
    chk("pending", 64'(pending), 64'(m_q.size() != 0));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("stale", 64'(stale), 64'(m_stale));
  endtask
  task automatic idle(input int n, input logic [SEL_W-1:0] s);
    for (int i = 0; i < n; i++) step(1'b0, s, '0, 1'b0);
  endtask
  initial begin
    step(1'b1, 2'd1, 3'b111, 1'b1);
    step(1'b1, 2'd0, 3'b111, 1'b1);
    step(1'b0, 2'd1, 3'b010, 1'b0);
    idle(4, 2'd1);
    step(1'b0, 2'd1, '0, 1'b1);
    idle(1, 2'd1);
    step(1'b0, 2'd0, 3'b001, 1'b0);
    idle(9, 2'd0);
    step(1'b0, 2'd0, 3'b001, 1'b0);
    idle(3, 2'd0);
    step(1'b0, 2'd0, '0, 1'b1);
    step(1'b0, 2'd0, 3'b001, 1'b0);
    step(1'b0, 2'd0, 3'b001, 1'b1);
    step(1'b0, 2'd1, '0, 1'b0);
    step(1'b0, 2'd1, '0, 1'b1);
    step(1'b0, 2'd1, 3'b101, 1'b1);
    step(1'b0, 2'd3, 3'b111, 1'b1);
    step(1'b0, 2'd3, 3'b111, 1'b0);
    step(1'b0, 2'd0, 3'b001, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 2'd0, 3'b001, 1'b0);
    step(1'b0, 2'd0, 3'b001, 1'b1);
    idle(TMO + 10, 2'd0);
    step(1'b0, 2'd0, 3'b001, 1'b0);
    step(1'b0, 2'd0, '0, 1'b1);
    step(1'b0, 2'd2, 3'b100, 1'b0);
    step(1'b1, 2'd2, 3'b100, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic [SEL_W-1:0] s;
      s = ($urandom_range(15) == 0) ? SEL_W'($urandom) : m_sel;
      step($urandom_range(499) == 0, s, NUM_SRC'($urandom), $urandom_range(3) == 0);
    end
    idle(TMO + 5, m_sel);
    step(1'b0, 2'd1, 3'b010, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
